// File: rtl/soc_decerr_slave.sv
// Default AXI4 slave: answers every unmapped request with DECERR, one outstanding read and write each.
// First R beat one cycle after AR; all outputs hold under backpressure. Keeps a saturating error count and the first faulting address.
module soc_decerr_slave #(
    parameter int IdWidth   = 8,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 clr_i,
    output logic [31:0]          err_cnt_o,
    output logic [AddrWidth-1:0] err_addr_o
);

    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    r_state_t               r_state_q, r_state_d;
    w_state_t               w_state_q, w_state_d;
    logic [IdWidth-1:0]     r_id_q, b_id_q;
    logic [7:0]             r_len_q, r_beat_q;
    logic [31:0]            err_cnt_q, err_cnt_d;
    logic [AddrWidth-1:0]   err_addr_q;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [1:0]  hs_cnt;
    logic [31:0] cnt_base;
    logic [32:0] cnt_sum;
    logic        addr_capture;

    assign ar_hs = ar_valid_i && ar_ready_o;
    assign r_hs  = r_valid_o && r_ready_i;
    assign aw_hs = aw_valid_i && aw_ready_o;
    assign w_hs  = w_valid_i && w_ready_o;
    assign b_hs  = b_valid_o && b_ready_i;

    assign r_id_o   = r_id_q;
    assign r_data_o = '0;
    assign r_resp_o = 2'b11;
    assign b_id_o   = b_id_q;
    assign b_resp_o = 2'b11;

    always_comb begin
        r_state_d  = r_state_q;
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        r_last_o   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ar_ready_o = 1'b1;
                if (ar_valid_i) r_state_d = R_RESP;
            end
            R_RESP: begin
                r_valid_o = 1'b1;
                r_last_o  = (r_beat_q == r_len_q);
                if (r_ready_i && r_last_o) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // W beats arriving before AW are held off by keeping w_ready low in idle.
    always_comb begin
        w_state_d  = w_state_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_ready_o = 1'b1;
                if (aw_valid_i) w_state_d = W_DATA;
            end
            W_DATA: begin
                w_ready_o = 1'b1;
                if (w_valid_i && w_last_i) w_state_d = W_RESP;
            end
            W_RESP: begin
                b_valid_o = 1'b1;
                if (b_ready_i) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Clear restarts the log from this cycle's handshakes rather than from zero.
    always_comb begin
        hs_cnt       = {1'b0, ar_hs} + {1'b0, aw_hs};
        cnt_base     = clr_i ? 32'd0 : err_cnt_q;
        cnt_sum      = {1'b0, cnt_base} + {31'd0, hs_cnt};
        err_cnt_d    = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
        addr_capture = clr_i || (err_cnt_q == 32'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q  <= R_IDLE;
            w_state_q  <= W_IDLE;
            r_id_q     <= '0;
            r_len_q    <= '0;
            r_beat_q   <= '0;
            b_id_q     <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            if (ar_hs) begin
                r_id_q   <= ar_id_i;
                r_len_q  <= ar_len_i;
                r_beat_q <= '0;
            end else if (r_hs) begin
                r_beat_q <= r_beat_q + 8'd1;
            end
            if (aw_hs) b_id_q <= aw_id_i;
            err_cnt_q <= err_cnt_d;
            if (addr_capture) begin
                if (ar_hs)      err_addr_q <= ar_addr_i;
                else if (aw_hs) err_addr_q <= aw_addr_i;
                else if (clr_i) err_addr_q <= '0;
            end
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;

    // w_hs and b_hs are folded into the FSM next-state terms; kept named for readability.
    logic unused_hs;
    assign unused_hs = w_hs ^ b_hs;

endmodule
